// File: rtl/pipe_op_tracker_pkg.sv
// Shared opcode constants and stall-counter sizing for the pipeline opcode
// tracker and the branch/A-type hazard control unit.
package pipe_op_tracker_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ATYPE = 4'b0001;
  localparam logic [OP_W-1:0] OP_LW    = 4'b0110;
  localparam logic [OP_W-1:0] OP_LWALT = 4'b0100;
  localparam logic [OP_W-1:0] OP_BR0   = 4'b1100;
  localparam logic [OP_W-1:0] OP_BR1   = 4'b1101;
  localparam logic [OP_W-1:0] OP_BR2   = 4'b1110;

  // Bits needed to count 0..max_stall inclusive.
  function automatic int stall_cnt_w(input int max_stall);
    return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
  endfunction

endpackage

// File: rtl/pipe_op_tracker_if.sv
// Opcode / stall bus between the tracker (slave) and the hazard control side
// (master). StallTimeout exists only when PIPE_STALL_WATCHDOG_EN is defined.
interface pipe_op_tracker_if;
  import pipe_op_tracker_pkg::*;

  // No valid/ready handshake: StopPC and Flush are level signals sampled on
  // every rising edge; opcode outputs are valid every cycle after reset.
  logic [OP_W-1:0] IFOP;
  logic            StopPC;
  logic            Flush;
  logic [OP_W-1:0] IDOP;
  logic [OP_W-1:0] EXOP;
  logic [OP_W-1:0] MEMOP;
  logic [OP_W-1:0] WBOP;
  logic            PCWrite;
  logic            IFIDWrite;
  logic            IDEXBubble;
`ifdef PIPE_STALL_WATCHDOG_EN
  logic            StallTimeout;
`endif

  modport master (
    output IFOP, StopPC, Flush,
    input  IDOP, EXOP, MEMOP, WBOP, PCWrite, IFIDWrite, IDEXBubble
`ifdef PIPE_STALL_WATCHDOG_EN
    , input StallTimeout
`endif
  );

  modport slave (
    input  IFOP, StopPC, Flush,
    output IDOP, EXOP, MEMOP, WBOP, PCWrite, IFIDWrite, IDEXBubble
`ifdef PIPE_STALL_WATCHDOG_EN
    , output StallTimeout
`endif
  );

endinterface

// File: rtl/pipe_op_tracker_op_stage_reg.sv
// One pipeline opcode register: async reset to the NOP opcode, load-NOP has
// priority over the enable.
module op_stage_reg
  import pipe_op_tracker_pkg::*;
#(
  parameter logic [OP_W-1:0] NOP_OP = OP_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load_nop,
  input  logic [OP_W-1:0] d,
  output logic [OP_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= NOP_OP;
    end else if (load_nop) begin
      q <= NOP_OP;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_op_tracker.sv
// Per-stage opcode tracker with stall/bubble and flush/squash control.
// Optional stall watchdog enabled by defining PIPE_STALL_WATCHDOG_EN.
module pipe_op_tracker
  import pipe_op_tracker_pkg::*;
#(
  parameter logic [OP_W-1:0] NOP_OP = OP_NOP
`ifdef PIPE_STALL_WATCHDOG_EN
  , parameter int MAX_STALL = 3
`endif
) (
  input  logic                clk,
  input  logic                rst,
  pipe_op_tracker_if.slave    bus
);

  logic eff_stall;

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam int CW = stall_cnt_w(MAX_STALL);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);

  logic [CW-1:0] stall_cnt;
  logic          timeout_q;
  logic          release_now;

  // A stall that has already lasted MAX_STALL cycles is let through once.
  assign release_now = bus.StopPC && (stall_cnt == CNT_MAX);
  assign eff_stall   = bus.StopPC && !release_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!bus.StopPC || release_now) begin
        stall_cnt <= '0;
      end else if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (release_now) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.StallTimeout = timeout_q;
`else
  assign eff_stall = bus.StopPC;
`endif

  assign bus.PCWrite    = !eff_stall;
  assign bus.IFIDWrite  = !eff_stall;
  assign bus.IDEXBubble = eff_stall;

  // A stall outranks a flush: a branch stalled in ID has not resolved.
  op_stage_reg #(.NOP_OP(NOP_OP)) u_id (
    .clk      (clk),
    .rst      (rst),
    .en       (!eff_stall),
    .load_nop (bus.Flush && !eff_stall),
    .d        (bus.IFOP),
    .q        (bus.IDOP)
  );

  op_stage_reg #(.NOP_OP(NOP_OP)) u_ex (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .load_nop (eff_stall),
    .d        (bus.IDOP),
    .q        (bus.EXOP)
  );

  op_stage_reg #(.NOP_OP(NOP_OP)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .load_nop (1'b0),
    .d        (bus.EXOP),
    .q        (bus.MEMOP)
  );

  op_stage_reg #(.NOP_OP(NOP_OP)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .load_nop (1'b0),
    .d        (bus.MEMOP),
    .q        (bus.WBOP)
  );

endmodule

// File: tb/tb_pipe_op_tracker.sv
// Directed bench for pipe_op_tracker: shift, stall bubbles, flush squash,
// stall-over-flush priority, async reset mid-stall and the optional watchdog.
module tb_pipe_op_tracker;
  import pipe_op_tracker_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipe_op_tracker_if bus_if();

  pipe_op_tracker u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ops(input string tag, input logic [3:0] id, input logic [3:0] ex,
                           input logic [3:0] mem, input logic [3:0] wb);
    check({tag, ".id"},  32'(bus_if.IDOP),  32'(id));
    check({tag, ".ex"},  32'(bus_if.EXOP),  32'(ex));
    check({tag, ".mem"}, 32'(bus_if.MEMOP), 32'(mem));
    check({tag, ".wb"},  32'(bus_if.WBOP),  32'(wb));
  endtask

  task automatic check_ctl(input string tag, input logic stall);
    check({tag, ".pcw"},    32'(bus_if.PCWrite),    32'(!stall));
    check({tag, ".ifidw"},  32'(bus_if.IFIDWrite),  32'(!stall));
    check({tag, ".bubble"}, 32'(bus_if.IDEXBubble), 32'(stall));
  endtask

  // driver: advance one edge, settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic stop, input logic flush);
    bus_if.IFOP   = op;
    bus_if.StopPC = stop;
    bus_if.Flush  = flush;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check_ops("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    check_ctl("reset", 1'b0);
`ifdef PIPE_STALL_WATCHDOG_EN
    check("reset.timeout", 32'(bus_if.StallTimeout), 32'd0);
`endif
    rst = 1'b0;

    // normal shift 1,6,12,1
    drive(OP_ATYPE, 1'b0, 1'b0); step(); check_ops("sh1", 4'h1, 4'h0, 4'h0, 4'h0);
    drive(OP_LW,    1'b0, 1'b0); step(); check_ops("sh2", 4'h6, 4'h1, 4'h0, 4'h0);
    drive(OP_BR0,   1'b0, 1'b0); step(); check_ops("sh3", 4'hc, 4'h6, 4'h1, 4'h0);
    drive(OP_ATYPE, 1'b0, 1'b0); step(); check_ops("sh4", 4'h1, 4'hc, 4'h6, 4'h1);

    // set up ID=1, EX=6 then one-cycle stall
    drive(OP_LW,    1'b0, 1'b0); step(); check_ops("pre1", 4'h6, 4'h1, 4'hc, 4'h6);
    drive(OP_ATYPE, 1'b0, 1'b0); step(); check_ops("pre2", 4'h1, 4'h6, 4'h1, 4'hc);
    drive(OP_BR0, 1'b1, 1'b0);
    check_ctl("stall1.ctl", 1'b1);
    step(); check_ops("stall1", 4'h1, 4'h0, 4'h6, 4'h1);

    // branch in ID, two-cycle stall
    drive(OP_BR0, 1'b0, 1'b0);
    check_ctl("run.ctl", 1'b0);
    step(); check_ops("br_in", 4'hc, 4'h1, 4'h0, 4'h6);
    drive(OP_ATYPE, 1'b1, 1'b0); step(); check_ops("br_s1", 4'hc, 4'h0, 4'h1, 4'h0);
    drive(OP_ATYPE, 1'b1, 1'b0); step(); check_ops("br_s2", 4'hc, 4'h0, 4'h0, 4'h1);
    drive(OP_ATYPE, 1'b0, 1'b0); step(); check_ops("br_go", 4'h1, 4'hc, 4'h0, 4'h0);

    // flush squashes IF while the branch advances
    drive(OP_BR1, 1'b0, 1'b0); step(); check_ops("fl_pre", 4'hd, 4'h1, 4'hc, 4'h0);
    drive(OP_ATYPE, 1'b0, 1'b1);
    check_ctl("flush.ctl", 1'b0);
    step(); check_ops("flush", 4'h0, 4'hd, 4'h1, 4'hc);

    // stall beats flush
    drive(OP_LWALT, 1'b0, 1'b0); step(); check_ops("sf_pre", 4'h4, 4'h0, 4'hd, 4'h1);
    drive(OP_ATYPE, 1'b1, 1'b1); step(); check_ops("sf", 4'h4, 4'h0, 4'h0, 4'hd);

    // six-cycle stall with BR2 in ID
    drive(OP_BR2, 1'b0, 1'b0); step(); check_ops("wd_pre", 4'he, 4'h4, 4'h0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
`ifdef PIPE_STALL_WATCHDOG_EN
      logic rel;
      rel = (c == 4);
`else
      logic rel;
      rel = 1'b0;
`endif
      drive(OP_ATYPE, 1'b1, 1'b0);
      check($sformatf("wd_c%0d.pcw", c), 32'(bus_if.PCWrite), 32'(rel));
      step();
      check($sformatf("wd_c%0d.id", c), 32'(bus_if.IDOP), (c >= 4 && rel) || (c > 4 && `ifdef PIPE_STALL_WATCHDOG_EN 1'b1 `else 1'b0 `endif) ? 32'h1 : 32'he);
`ifdef PIPE_STALL_WATCHDOG_EN
      check($sformatf("wd_c%0d.timeout", c), 32'(bus_if.StallTimeout), 32'(c >= 4));
`endif
    end
    drive(OP_ATYPE, 1'b0, 1'b0); step();
`ifdef PIPE_STALL_WATCHDOG_EN
    check("wd_sticky", 32'(bus_if.StallTimeout), 32'd1);
`endif

    // async reset mid-stall, then first edge loads IFOP
    drive(OP_LW, 1'b0, 1'b0); step();
    drive(OP_LW, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_ops("arst", 4'h0, 4'h0, 4'h0, 4'h0);
    check_ctl("arst.ctl", 1'b1);
`ifdef PIPE_STALL_WATCHDOG_EN
    check("arst.timeout", 32'(bus_if.StallTimeout), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(OP_LW, 1'b0, 1'b0);
    step(); check_ops("post_rst", 4'h6, 4'h0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
